// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, sequencer state encoding and mux-select codes
// shared by the LC-3 control unit and the datapath.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ALU, S_LEA, S_BR, S_JMP, S_JSR1, S_JSR2,
        S_ADDR, S_RD1, S_IND, S_RD2, S_LDWB,
        S_STDATA, S_WR,
        S_TRAP1, S_TRAP2, S_TRAP3, S_TRAP4,
        S_HALT
    } state_e;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDER = 2'd2;

    localparam logic ADDR1_PC  = 1'b0;
    localparam logic ADDR1_SR1 = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'd0;
    localparam logic [1:0] ADDR2_OFF6  = 2'd1;
    localparam logic [1:0] ADDR2_OFF9  = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;

    localparam logic MARMUX_ZEXT  = 1'b0;
    localparam logic MARMUX_ADDER = 1'b1;

    localparam logic DRMUX_IR = 1'b0;
    localparam logic DRMUX_R7 = 1'b1;

    localparam logic SR1MUX_IR11 = 1'b0;
    localparam logic SR1MUX_IR8  = 1'b1;

    localparam logic MDRMUX_BUS = 1'b0;
    localparam logic MDRMUX_MEM = 1'b1;

    localparam logic [1:0] ALUK_ADD   = 2'd0;
    localparam logic [1:0] ALUK_AND   = 2'd1;
    localparam logic [1:0] ALUK_NOT   = 2'd2;
    localparam logic [1:0] ALUK_PASSA = 2'd3;

    typedef struct packed {
        logic       ldMAR;
        logic       ldMDR;
        logic       ldIR;
        logic       ldPC;
        logic       ldReg;
        logic       flagWE;
        logic       gatePC;
        logic       gateMDR;
        logic       gateALU;
        logic       gateMARMUX;
        logic       memEN;
        logic       memWE;
        logic [1:0] pcMux;
        logic       addr1Mux;
        logic [1:0] addr2Mux;
        logic       marMux;
        logic       drMux;
        logic       sr1Mux;
        logic       mdrMux;
        logic [1:0] aluK;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/lc3_branch_eval.sv
// lc3_branch_eval: BR taken decision from the IR n/z/p mask
// and the registered condition codes.
module lc3_branch_eval (
    input  logic [2:0] i_nzp,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_p,
    output logic       o_taken
);

    assign o_taken = (i_nzp[2] & i_n) | (i_nzp[1] & i_z) | (i_nzp[0] & i_p);

endmodule

// File: rtl/lc3_control.sv
// lc3_control: multi-cycle LC-3 Moore sequencer driving datapath controls.
// Define LC3_TRAP_EN to execute TRAP; otherwise opcode 1111 halts.
module lc3_control
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic        memRdy,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        ldPC,
    output logic        ldReg,
    output logic        flagWE,
    output logic        gatePC,
    output logic        gateMDR,
    output logic        gateALU,
    output logic        gateMARMUX,
    output logic        memEN,
    output logic        memWE,
    output logic [1:0]  pcMux,
    output logic        addr1Mux,
    output logic [1:0]  addr2Mux,
    output logic        marMux,
    output logic        drMux,
    output logic        sr1Mux,
    output logic        mdrMux,
    output logic [1:0]  aluK,
    output logic        halted
);

    state_e  r_state;
    state_e  w_next;
    opcode_e w_op;
    ctrl_t   w_ctrl;
    ctrl_t   w_out;
    logic    w_taken;
    logic    w_base;
    logic    w_unused;

    assign w_op     = opcode_e'(IR[15:12]);
    assign w_base   = (w_op == OP_LDR) || (w_op == OP_STR);
    assign w_unused = ^IR[8:0];

    lc3_branch_eval u_branch_eval (
        .i_nzp   (IR[11:9]),
        .i_n     (N),
        .i_z     (Z),
        .i_p     (P),
        .o_taken (w_taken)
    );

    // State register; reset restarts at instruction fetch
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH1;
        else       r_state <= w_next;
    end

    // Next-state: sequence per opcode, memory states wait on memRdy
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: if (memRdy) w_next = S_FETCH3;
            S_FETCH3: w_next = S_DECODE;
            S_DECODE: begin
                unique case (w_op)
                    OP_ADD, OP_AND, OP_NOT: w_next = S_ALU;
                    OP_LEA: w_next = S_LEA;
                    OP_BR:  w_next = w_taken ? S_BR : S_FETCH1;
                    OP_JMP: w_next = S_JMP;
                    OP_JSR: w_next = S_JSR1;
                    OP_LD, OP_LDR, OP_LDI,
                    OP_ST, OP_STR, OP_STI: w_next = S_ADDR;
`ifdef LC3_TRAP_EN
                    OP_TRAP: w_next = S_TRAP1;
`else
                    OP_TRAP: w_next = S_HALT;
`endif
                    default: w_next = S_HALT;
                endcase
            end
            S_ALU, S_LEA, S_BR, S_JMP,
            S_JSR2, S_LDWB, S_TRAP4: w_next = S_FETCH1;
            S_JSR1: w_next = S_JSR2;
            S_ADDR: begin
                if ((w_op == OP_LDI) || (w_op == OP_STI))
                    w_next = S_RD1;
                else if ((w_op == OP_ST) || (w_op == OP_STR))
                    w_next = S_STDATA;
                else
                    w_next = S_RD2;
            end
            S_RD1:    if (memRdy) w_next = S_IND;
            S_IND:    w_next = (w_op == OP_STI) ? S_STDATA : S_RD2;
            S_RD2:    if (memRdy) w_next = S_LDWB;
            S_STDATA: w_next = S_WR;
            S_WR:     if (memRdy) w_next = S_FETCH1;
            S_TRAP1:  w_next = S_TRAP2;
            S_TRAP2:  w_next = S_TRAP3;
            S_TRAP3:  if (memRdy) w_next = S_TRAP4;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH1;
        endcase
    end

    // Output decode from current state and IR fields
    always_comb begin
        w_ctrl = '0;
        unique case (r_state)
            S_FETCH1: begin
                w_ctrl.gatePC = 1'b1;
                w_ctrl.ldMAR  = 1'b1;
                w_ctrl.ldPC   = 1'b1;
                w_ctrl.pcMux  = PCMUX_INC;
            end
            S_FETCH2, S_RD1, S_RD2, S_TRAP3: begin
                w_ctrl.memEN  = 1'b1;
                w_ctrl.mdrMux = MDRMUX_MEM;
                w_ctrl.ldMDR  = 1'b1;
            end
            S_FETCH3: begin
                w_ctrl.gateMDR = 1'b1;
                w_ctrl.ldIR    = 1'b1;
            end
            S_ALU: begin
                w_ctrl.gateALU = 1'b1;
                w_ctrl.ldReg   = 1'b1;
                w_ctrl.flagWE  = 1'b1;
                w_ctrl.drMux   = DRMUX_IR;
                w_ctrl.sr1Mux  = SR1MUX_IR8;
                w_ctrl.aluK    = (w_op == OP_AND) ? ALUK_AND :
                                 (w_op == OP_NOT) ? ALUK_NOT : ALUK_ADD;
            end
            S_LEA: begin
                w_ctrl.gateMARMUX = 1'b1;
                w_ctrl.marMux     = MARMUX_ADDER;
                w_ctrl.addr1Mux   = ADDR1_PC;
                w_ctrl.addr2Mux   = ADDR2_OFF9;
                w_ctrl.ldReg      = 1'b1;
                w_ctrl.flagWE     = 1'b1;
            end
            S_BR: begin
                w_ctrl.ldPC     = 1'b1;
                w_ctrl.pcMux    = PCMUX_ADDER;
                w_ctrl.addr1Mux = ADDR1_PC;
                w_ctrl.addr2Mux = ADDR2_OFF9;
            end
            S_JMP: begin
                w_ctrl.ldPC     = 1'b1;
                w_ctrl.pcMux    = PCMUX_ADDER;
                w_ctrl.addr1Mux = ADDR1_SR1;
                w_ctrl.addr2Mux = ADDR2_ZERO;
                w_ctrl.sr1Mux   = SR1MUX_IR8;
            end
            S_JSR1, S_TRAP1: begin
                w_ctrl.gatePC = 1'b1;
                w_ctrl.drMux  = DRMUX_R7;
                w_ctrl.ldReg  = 1'b1;
            end
            S_JSR2: begin
                w_ctrl.ldPC  = 1'b1;
                w_ctrl.pcMux = PCMUX_ADDER;
                if (IR[11]) begin
                    w_ctrl.addr1Mux = ADDR1_PC;
                    w_ctrl.addr2Mux = ADDR2_OFF11;
                end else begin
                    w_ctrl.addr1Mux = ADDR1_SR1;
                    w_ctrl.addr2Mux = ADDR2_ZERO;
                    w_ctrl.sr1Mux   = SR1MUX_IR8;
                end
            end
            S_ADDR: begin
                w_ctrl.gateMARMUX = 1'b1;
                w_ctrl.marMux     = MARMUX_ADDER;
                w_ctrl.ldMAR      = 1'b1;
                if (w_base) begin
                    w_ctrl.addr1Mux = ADDR1_SR1;
                    w_ctrl.sr1Mux   = SR1MUX_IR8;
                    w_ctrl.addr2Mux = ADDR2_OFF6;
                end else begin
                    w_ctrl.addr1Mux = ADDR1_PC;
                    w_ctrl.addr2Mux = ADDR2_OFF9;
                end
            end
            S_IND: begin
                w_ctrl.gateMDR = 1'b1;
                w_ctrl.ldMAR   = 1'b1;
            end
            S_LDWB: begin
                w_ctrl.gateMDR = 1'b1;
                w_ctrl.ldReg   = 1'b1;
                w_ctrl.flagWE  = 1'b1;
                w_ctrl.drMux   = DRMUX_IR;
            end
            S_STDATA: begin
                w_ctrl.sr1Mux  = SR1MUX_IR11;
                w_ctrl.aluK    = ALUK_PASSA;
                w_ctrl.gateALU = 1'b1;
                w_ctrl.mdrMux  = MDRMUX_BUS;
                w_ctrl.ldMDR   = 1'b1;
            end
            S_WR: begin
                w_ctrl.memEN = 1'b1;
                w_ctrl.memWE = 1'b1;
            end
            S_TRAP2: begin
                w_ctrl.gateMARMUX = 1'b1;
                w_ctrl.marMux     = MARMUX_ZEXT;
                w_ctrl.ldMAR      = 1'b1;
            end
            S_TRAP4: begin
                w_ctrl.gateMDR = 1'b1;
                w_ctrl.ldPC    = 1'b1;
                w_ctrl.pcMux   = PCMUX_BUS;
            end
            S_HALT:   w_ctrl.halted = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

    // Reset forces every output low, even before the state register clears
    always_comb begin
        w_out = reset ? '0 : w_ctrl;
    end

    assign {ldMAR, ldMDR, ldIR, ldPC, ldReg, flagWE,
            gatePC, gateMDR, gateALU, gateMARMUX, memEN, memWE,
            pcMux, addr1Mux, addr2Mux, marMux, drMux, sr1Mux,
            mdrMux, aluK, halted} = w_out;

endmodule
